// File: rtl/tlb_l2_responder.sv
// L2 TLB responder: queues translation requests and walks them one at a time, then returns one response pulse per walk.
// Latency is 3 cycles plus walker latency from req to data_valid; ready drops when the FIFO is full and unaccepted requests are dropped.
module tlb_l2_responder #(
    parameter int DEPTH   = 4,
    parameter int VPN_W   = 27,
    parameter int PN      = 3,
    parameter int INFO_W  = 8,
    parameter int ENTRY_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [VPN_W-1:0]   req_addr,
    input  logic [INFO_W-1:0]  req_info,
    output logic               ready,
    output logic               data_valid,
    output logic [INFO_W-1:0]  info_o,
    output logic [ENTRY_W-1:0] entry,
    output logic [PN-1:0]      wpn,
    output logic [VPN_W-1:0]   waddr,
    output logic               error,
    output logic               exception,
    output logic               exc_static,
    output logic               walk_req,
    output logic [VPN_W-1:0]   walk_vpn,
    input  logic               walk_ready,
    input  logic               walk_valid,
    input  logic [ENTRY_W-1:0] walk_entry,
    input  logic [1:0]         walk_level,
    input  logic               walk_exception,
    input  logic               walk_error,
    input  logic               walk_exc_static,
    input  logic               flush
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [VPN_W-1:0]  fifo_vpn  [DEPTH];
    logic [INFO_W-1:0] fifo_info [DEPTH];
    logic [AW:0]       head, tail, count;
    logic              enq, deq, capture, nonempty;
    logic              stale, stale_now, resp_err;
    logic [PN-1:0]     wpn_c;

    assign ready    = (count != FULL);
    assign enq      = req & ready;
    // An enqueue this cycle counts as non-empty so the walk issues one cycle after acceptance.
    assign nonempty = (count != '0) | enq;
    assign walk_vpn = fifo_vpn[head[AW-1:0]];

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_vpn[tail[AW-1:0]]  <= req_addr;
            fifo_info[tail[AW-1:0]] <= req_info;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + ONE;
            if (deq) head <= head + ONE;
            if (enq && !deq)      count <= count + ONE;
            else if (!enq && deq) count <= count - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        deq       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE:  if (nonempty) state_nxt = ISSUE;
            ISSUE: if (walk_ready) begin
                       deq       = 1'b1;
                       state_nxt = WAIT;
                   end
            WAIT:  if (walk_valid) begin
                       capture   = 1'b1;
                       state_nxt = RESP;
                   end
            RESP:  state_nxt = nonempty ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A fence only poisons a walk already handed to the walker.
    assign stale_now = flush & (deq | (state == WAIT));
    assign resp_err  = walk_error | stale | stale_now;

    always_comb begin
        wpn_c = '0;
        for (int j = 0; j < PN; j++) wpn_c[j] = (j < int'(walk_level));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            walk_req   <= 1'b0;
            data_valid <= 1'b0;
            info_o     <= '0;
            waddr      <= '0;
            entry      <= '0;
            wpn        <= '0;
            error      <= 1'b0;
            exception  <= 1'b0;
            exc_static <= 1'b0;
            stale      <= 1'b0;
        end else begin
            walk_req   <= (state_nxt == ISSUE);
            data_valid <= (state_nxt == RESP);
            if (deq) begin
                waddr  <= walk_vpn;
                info_o <= fifo_info[head[AW-1:0]];
            end
            if (capture) begin
                entry      <= walk_entry;
                wpn        <= wpn_c;
                error      <= resp_err;
                exception  <= walk_exception & ~resp_err;
                exc_static <= walk_exc_static & walk_exception & ~resp_err;
            end
            if (state == RESP)  stale <= 1'b0;
            else if (stale_now) stale <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tlb_l2_responder.sv
// Bench for tlb_l2_responder: directed scenarios plus a random phase, checked against a queue-based walker/requester model.
module tb_tlb_l2_responder;
    localparam int DEPTH = 4, VPN_W = 27, PN = 3, INFO_W = 8, ENTRY_W = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req = 1'b0, flush = 1'b0;
    logic [VPN_W-1:0] req_addr = '0;
    logic [INFO_W-1:0] req_info = '0;
    logic ready, data_valid, error, exception, exc_static, walk_req;
    logic [INFO_W-1:0] info_o;
    logic [ENTRY_W-1:0] entry;
    logic [PN-1:0] wpn;
    logic [VPN_W-1:0] waddr, walk_vpn;
    logic walk_ready = 1'b0, walk_valid = 1'b0;
    logic [ENTRY_W-1:0] walk_entry = '0;
    logic [1:0] walk_level = '0;
    logic walk_exception = 1'b0, walk_error = 1'b0, walk_exc_static = 1'b0;

    always #5 clk = ~clk;

    tlb_l2_responder #(.DEPTH(DEPTH), .VPN_W(VPN_W), .PN(PN), .INFO_W(INFO_W), .ENTRY_W(ENTRY_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_info(req_info), .ready(ready),
        .data_valid(data_valid), .info_o(info_o), .entry(entry), .wpn(wpn), .waddr(waddr),
        .error(error), .exception(exception), .exc_static(exc_static),
        .walk_req(walk_req), .walk_vpn(walk_vpn), .walk_ready(walk_ready), .walk_valid(walk_valid),
        .walk_entry(walk_entry), .walk_level(walk_level), .walk_exception(walk_exception),
        .walk_error(walk_error), .walk_exc_static(walk_exc_static), .flush(flush)
    );

    typedef struct { logic [VPN_W-1:0] addr; logic [INFO_W-1:0] info; } req_t;
    typedef struct {
        logic [VPN_W-1:0] addr; logic [INFO_W-1:0] info; logic [ENTRY_W-1:0] entry;
        logic [PN-1:0] wpn; logic err; logic exc; logic excs;
    } rsp_t;

    req_t q[$];
    rsp_t exp_q[$];
    req_t inflight;
    bit walking = 0, stale_m = 0, wr_exp = 0;
    int lat_cnt = 0;
    int total = 0, passed = 0, fails = 0, cyc = 0, dv_count = 0, dv_cyc = 0;
    logic obs_err[$];
    logic obs_exc[$];

    // walker behaviour knobs
    int ready_mode = 1, lat_min = 0, lat_max = 0;
    bit fields_rand = 0;
    logic [ENTRY_W-1:0] k_entry = '0;
    logic [1:0] k_level = '0;
    logic k_exc = 0, k_err = 0, k_excs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model_rsp(input req_t r, input logic [ENTRY_W-1:0] e, input logic [1:0] lvl,
                                       input logic x, input logic er, input logic xs, input bit st);
        rsp_t p;
        p.addr  = r.addr;
        p.info  = r.info;
        p.entry = e;
        p.wpn   = PN'((1 << int'(lvl)) - 1);
        p.err   = er | st;
        p.exc   = x & ~p.err;
        p.excs  = xs & p.exc;
        return p;
    endfunction

    // One clock: model the edge, check outputs #1 after it, then drive walker inputs for the next cycle.
    task automatic step();
        bit acc, pop, wv, fl_st;
        rsp_t e;
        acc   = req && (q.size() != DEPTH);
        pop   = wr_exp && walk_ready;
        wv    = walk_valid && walking;
        fl_st = flush && (pop || walking);
        if (wv) exp_q.push_back(model_rsp(inflight, walk_entry, walk_level, walk_exception,
                                          walk_error, walk_exc_static, stale_m || fl_st));
        @(posedge clk); #1;
        cyc++;
        if (pop) begin
            inflight = q.pop_front();
            walking  = 1;
            lat_cnt  = int'($urandom_range(lat_max, lat_min));
        end
        if (acc) q.push_back(req_t'{req_addr, req_info});
        req   = 0;
        flush = 0;
        if (fl_st) stale_m = 1;
        if (wv) begin walking = 0; stale_m = 0; end
        wr_exp = (q.size() != 0) && !walking && !wv;
        chk("data_valid", 64'(data_valid), 64'(wv));
        chk("ready", 64'(ready), 64'(q.size() != DEPTH));
        chk("walk_req", 64'(walk_req), 64'(wr_exp));
        if (wr_exp) chk("walk_vpn", 64'(walk_vpn), 64'(q[0].addr));
        if (data_valid) begin
            dv_count++;
            dv_cyc = cyc;
            obs_err.push_back(error);
            obs_exc.push_back(exception);
        end
        if (wv) begin
            e = exp_q.pop_front();
            chk("rsp_waddr", 64'(waddr), 64'(e.addr));
            chk("rsp_info", 64'(info_o), 64'(e.info));
            chk("rsp_entry", entry, e.entry);
            chk("rsp_wpn", 64'(wpn), 64'(e.wpn));
            chk("rsp_error", 64'(error), 64'(e.err));
            chk("rsp_exception", 64'(exception), 64'(e.exc));
            chk("rsp_exc_static", 64'(exc_static), 64'(e.excs));
        end
        walk_valid = 0;
        if (walking) begin
            if (lat_cnt == 0) begin
                if (fields_rand) begin
                    k_entry = {$urandom, $urandom};
                    k_level = 2'($urandom_range(0, 3));
                    k_exc   = 1'($urandom_range(0, 1));
                    k_err   = ($urandom_range(0, 3) == 0);
                    k_excs  = 1'($urandom_range(0, 1));
                end
                walk_valid      = 1;
                walk_entry      = k_entry;
                walk_level      = k_level;
                walk_exception  = k_exc;
                walk_error      = k_err;
                walk_exc_static = k_excs;
            end else lat_cnt--;
        end
        case (ready_mode)
            0:       walk_ready = 0;
            1:       walk_ready = 1;
            default: walk_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send(input logic [VPN_W-1:0] a, input logic [INFO_W-1:0] i);
        req = 1; req_addr = a; req_info = i;
        step();
    endtask

    task automatic run_until_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while ((q.size() != 0 || walking) && n < maxc) begin step(); n++; end
        chk(tag, 64'(q.size() == 0 && !walking), 64'(1));
    endtask

    task automatic wait_walking(input string tag, input int maxc);
        int n;
        n = 0;
        while (!walking && n < maxc) begin step(); n++; end
        chk(tag, 64'(walking), 64'(1));
    endtask

    task automatic do_reset();
        rst = 0; req = 0; flush = 0; walk_valid = 0; walk_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        q.delete(); exp_q.delete();
        walking = 0; stale_m = 0; wr_exp = 0;
    endtask

    initial begin
        int dv0, c0;
        do_reset();
        chk("rst_data_valid", 64'(data_valid), 64'(0));
        chk("rst_walk_req", 64'(walk_req), 64'(0));
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_exception", 64'(exception), 64'(0));
        chk("rst_exc_static", 64'(exc_static), 64'(0));
        chk("rst_wpn", 64'(wpn), 64'(0));
        chk("rst_info", 64'(info_o), 64'(0));
        chk("rst_entry", entry, 64'(0));
        chk("rst_waddr", 64'(waddr), 64'(0));
        step();

        // single request, walker latency 5
        ready_mode = 1; lat_min = 5; lat_max = 5; fields_rand = 0;
        k_entry = 64'hDEAD_BEEF_0000_1111; k_level = 0; k_exc = 0; k_err = 0; k_excs = 0;
        dv0 = dv_count; c0 = cyc;
        send(27'h1234, 8'h45);
        run_until_idle("single_timeout", 30);
        step();
        chk("single_pulses", 64'(dv_count - dv0), 64'(1));
        chk("single_latency", 64'(dv_cyc - c0), 64'(8));
        chk("single_waddr", 64'(waddr), 64'h1234);
        chk("single_info", 64'(info_o), 64'h45);
        chk("single_wpn", 64'(wpn), 64'(0));
        chk("single_error", 64'(error), 64'(0));

        // superpages
        lat_min = 2; lat_max = 2; k_level = 2;
        send(27'h2000, 8'h11);
        run_until_idle("sp2_timeout", 20);
        chk("sp2_wpn", 64'(wpn), 64'b011);
        k_level = 1;
        send(27'h3000, 8'h12);
        run_until_idle("sp1_timeout", 20);
        chk("sp1_wpn", 64'(wpn), 64'b001);
        k_level = 0;

        // full FIFO with the walker stalled
        ready_mode = 0; walk_ready = 0; dv0 = dv_count; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 5; i++) begin
            send(VPN_W'(32'h100 + i), INFO_W'(8'h20 + i));
            if (i == 3) chk("full_ready", 64'(ready), 64'(0));
        end
        ready_mode = 1;
        run_until_idle("full_timeout", 60);
        chk("full_pulses", 64'(dv_count - dv0), 64'(4));

        // fence during WAIT
        obs_err.delete(); obs_exc.delete();
        lat_min = 6; lat_max = 6; k_exc = 1;
        send(27'h4000, 8'h31);
        send(27'h5000, 8'h32);
        wait_walking("fence_walk", 10);
        step(); step();
        flush = 1;
        step();
        run_until_idle("fence_timeout", 40);
        chk("fence_pulses", 64'(obs_err.size()), 64'(2));
        if (obs_err.size() >= 2) begin
            chk("fence_stale_error", 64'(obs_err[0]), 64'(1));
            chk("fence_stale_exc", 64'(obs_exc[0]), 64'(0));
            chk("fence_next_error", 64'(obs_err[1]), 64'(0));
        end

        // page fault
        lat_min = 1; lat_max = 1; k_exc = 1; k_excs = 1; k_err = 0;
        send(27'h6000, 8'h40);
        run_until_idle("fault_timeout", 20);
        chk("fault_exception", 64'(exception), 64'(1));
        chk("fault_exc_static", 64'(exc_static), 64'(1));
        chk("fault_error", 64'(error), 64'(0));
        k_exc = 0; k_excs = 0;

        // reset mid-walk, then a late walk_valid
        lat_min = 20; lat_max = 20;
        send(27'h7ABC, 8'h55);
        wait_walking("rstw_walk", 10);
        step();
        rst = 0;
        #2;
        chk("rstw_async_waddr", 64'(waddr), 64'(0));
        do_reset();
        dv0 = dv_count;
        walk_valid = 1; walk_entry = 64'h1; walk_level = 0;
        step();
        step();
        chk("rstw_no_dv", 64'(dv_count - dv0), 64'(0));
        chk("rstw_ready", 64'(ready), 64'(1));
        chk("rstw_walk_req", 64'(walk_req), 64'(0));

        // random traffic
        ready_mode = 2; lat_min = 0; lat_max = 4; fields_rand = 1;
        for (int i = 0; i < 400; i++) begin
            req      = 1'($urandom_range(0, 1));
            req_addr = VPN_W'($urandom);
            req_info = INFO_W'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            step();
        end
        ready_mode = 1;
        run_until_idle("rand_drain", 200);
        chk("rand_exp_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
